uart_cfg_ctrl: RTL and testbench

Configuration controller for the UART datapath. It synchronizes and debounces the board configuration switches: baud select, eight-bit, parity enable and odd/even parity. It holds the active configuration that drives the transmitter and receiver. A new configuration is committed only when both engines are idle, so a frame is never sent or sampled with a mix of old and new settings. It sits between the top-level input buffers and the UART tx/rx engines.

---
 rtl/uart_cfg_ctrl_if.sv | 26 ++
 rtl/uart_cfg_ctrl.sv | 127 ++++++++++++
 tb/tb_uart_cfg_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cfg_ctrl_if.sv
// Switch, busy and active-configuration signals between the board-level
// input buffers, the UART engines and the configuration controller.
interface uart_cfg_ctrl_if;
  logic [3:0]  baud_sw;
  logic        eight_sw;
  logic        pen_sw;
  logic        ohel_sw;
  logic        tx_busy;
  logic        rx_busy;
  logic [18:0] baud_k;
  logic        eight;
  logic        pen;
  logic        ohel;
  logic        cfg_pending;
  logic        cfg_update;

  modport slave (
    input  baud_sw, eight_sw, pen_sw, ohel_sw, tx_busy, rx_busy,
    output baud_k, eight, pen, ohel, cfg_pending, cfg_update
  );

  modport master (
    output baud_sw, eight_sw, pen_sw, ohel_sw, tx_busy, rx_busy,
    input  baud_k, eight, pen, ohel, cfg_pending, cfg_update
  );
endinterface

// File: rtl/uart_cfg_ctrl.sv
// UART configuration controller: synchronizes and debounces the config
// switches and commits a new setting only while both engines are idle.
module uart_cfg_ctrl #(
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W         = 20
) (
  input logic            clk,
  input logic            rst_n,
  uart_cfg_ctrl_if.slave cfg_if
);
  localparam logic [6:0]       RESET_VEC  = 7'b1000_100;
  localparam logic [18:0]      RESET_K    = 19'd868;
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  logic [6:0]       sync1_q, sync1_d;
  logic [6:0]       sync2_q, sync2_d;
  logic [6:0]       prev_q, prev_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [6:0]       cand_q, cand_d;
  logic [6:0]       cand_cfg_q, cand_cfg_d;
  logic [18:0]      cand_k_q, cand_k_d;
  logic [6:0]       act_q, act_d;
  logic [18:0]      act_k_q, act_k_d;
  logic             cfg_update_q, cfg_update_d;
  state_t           state_q, state_d;

  function automatic logic [18:0] baud_lookup(input logic [3:0] sel);
    case (sel)
      4'd0:    return 19'd333333;
      4'd1:    return 19'd83333;
      4'd2:    return 19'd41667;
      4'd3:    return 19'd20833;
      4'd4:    return 19'd10417;
      4'd5:    return 19'd5208;
      4'd6:    return 19'd2604;
      4'd7:    return 19'd1736;
      4'd8:    return 19'd868;
      4'd9:    return 19'd434;
      4'd10:   return 19'd217;
      4'd11:   return 19'd109;
      default: return 19'd868;
    endcase
  endfunction

  // cand_cfg_q is the cand value that cand_k_q was looked up from, so the
  // FSM always compares and commits a consistent vector/bit-time pair.
  always_comb begin
    sync1_d    = {cfg_if.baud_sw, cfg_if.eight_sw, cfg_if.pen_sw, cfg_if.ohel_sw};
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    if (sync2_q != prev_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STABLE_MAX) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end
    if (stab_cnt_q != STABLE_MAX && stab_cnt_d == STABLE_MAX) begin
      cand_d = sync2_q;
    end
    cand_cfg_d = cand_q;
    cand_k_d   = baud_lookup(cand_q[6:3]);
  end

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    act_k_d      = act_k_q;
    cfg_update_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand_cfg_q != act_q) state_d = PENDING;
      end
      PENDING: begin
        if (cand_cfg_q == act_q) begin
          state_d = IDLE;
        end else if (!cfg_if.tx_busy && !cfg_if.rx_busy) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        act_d        = cand_cfg_q;
        act_k_d      = cand_k_q;
        cfg_update_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= RESET_VEC;
      sync2_q      <= RESET_VEC;
      prev_q       <= RESET_VEC;
      stab_cnt_q   <= '0;
      cand_q       <= RESET_VEC;
      cand_cfg_q   <= RESET_VEC;
      cand_k_q     <= RESET_K;
      act_q        <= RESET_VEC;
      act_k_q      <= RESET_K;
      cfg_update_q <= 1'b0;
      state_q      <= IDLE;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      stab_cnt_q   <= stab_cnt_d;
      cand_q       <= cand_d;
      cand_cfg_q   <= cand_cfg_d;
      cand_k_q     <= cand_k_d;
      act_q        <= act_d;
      act_k_q      <= act_k_d;
      cfg_update_q <= cfg_update_d;
      state_q      <= state_d;
    end
  end

  assign cfg_if.baud_k      = act_k_q;
  assign cfg_if.eight       = act_q[2];
  assign cfg_if.pen         = act_q[1];
  assign cfg_if.ohel        = act_q[0];
  assign cfg_if.cfg_pending = (state_q == PENDING);
  assign cfg_if.cfg_update  = cfg_update_q;
endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Self-checking bench for uart_cfg_ctrl: directed scenarios plus randomized
// switch/bounce/busy phases against a behavioural configuration model.
module tb_uart_cfg_ctrl;
  localparam logic [6:0] RESET_VEC = 7'b1000_100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_cfg_ctrl_if cfg ();

  uart_cfg_ctrl #(.STABLE_CYCLES(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg_if (cfg)
  );

  int baud_tab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                        868, 434, 217, 109, 868, 868, 868, 868};

  int         checks = 0;
  int         failures = 0;
  logic [6:0] act_m;
  logic [6:0] cur_drive;

  // Monitor: active outputs may only move together with a cfg_update pulse
  bit          mon_en = 1'b0;
  int          upd_cnt = 0;
  int          pend_cnt = 0;
  int          bad_cnt = 0;
  int          width_bad = 0;
  logic [21:0] out_prev;
  logic        upd_prev;

  always @(negedge clk) begin
    if (mon_en) begin
      if ({cfg.baud_k, cfg.eight, cfg.pen, cfg.ohel} != out_prev && !cfg.cfg_update) bad_cnt++;
      if (cfg.cfg_update && upd_prev) width_bad++;
      if (cfg.cfg_update) upd_cnt++;
      if (cfg.cfg_pending) pend_cnt++;
    end
    out_prev = {cfg.baud_k, cfg.eight, cfg.pen, cfg.ohel};
    upd_prev = cfg.cfg_update;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] vec, input logic tx, input logic rx);
    cfg.baud_sw  = vec[6:3];
    cfg.eight_sw = vec[2];
    cfg.pen_sw   = vec[1];
    cfg.ohel_sw  = vec[0];
    cfg.tx_busy  = tx;
    cfg.rx_busy  = rx;
    cur_drive    = vec;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_cfg(input string tag);
    checkOutput({tag, "_baud_k"}, 32'(cfg.baud_k), 32'(baud_tab[act_m[6:3]]));
    checkOutput({tag, "_eight"}, 32'(cfg.eight), 32'(act_m[2]));
    checkOutput({tag, "_pen"}, 32'(cfg.pen), 32'(act_m[1]));
    checkOutput({tag, "_ohel"}, 32'(cfg.ohel), 32'(act_m[0]));
  endtask

  task automatic wait_baud(input logic [18:0] target, input int limit);
    int n;
    n = 0;
    while (cfg.baud_k !== target && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int upd0;
    int pend0;
    logic [6:0] gv;
    logic [6:0] new_vec;
    logic tx;
    logic rx;
    int busy_len;
    int n_gl;

    // Reset with switches at the reset configuration
    rst_n = 1'b0;
    act_m = RESET_VEC;
    applyStimulus(RESET_VEC, 1'b0, 1'b0);
    tick(3);
    check_cfg("rst");
    checkOutput("rst_pending", 32'(cfg.cfg_pending), 0);
    checkOutput("rst_update", 32'(cfg.cfg_update), 0);
    rst_n = 1'b1;
    tick(1);
    mon_en = 1'b1;
    tick(100);
    checkOutput("idle_pend_cnt", pend_cnt, 0);
    checkOutput("idle_upd_cnt", upd_cnt, 0);
    check_cfg("idle");

    // Baud select 4 with both engines idle
    upd0 = upd_cnt;
    applyStimulus({4'd4, 1'b1, 1'b0, 1'b0}, 1'b0, 1'b0);
    wait_baud(19'd10417, 16);
    checkOutput("b4_latency_baud_k", 32'(cfg.baud_k), 10417);
    tick(5);
    act_m = cur_drive;
    check_cfg("b4");
    checkOutput("b4_upd_cnt", upd_cnt - upd0, 1);

    // Parity change held off by a busy transmitter
    upd0 = upd_cnt;
    applyStimulus({4'd4, 1'b1, 1'b1, 1'b1}, 1'b1, 1'b0);
    tick(500);
    checkOutput("txbusy_pending", 32'(cfg.cfg_pending), 1);
    checkOutput("txbusy_pen", 32'(cfg.pen), 0);
    checkOutput("txbusy_upd_cnt", upd_cnt - upd0, 0);
    applyStimulus(cur_drive, 1'b0, 1'b0);
    tick(2);
    checkOutput("txdrop_pen", 32'(cfg.pen), 1);
    checkOutput("txdrop_ohel", 32'(cfg.ohel), 1);
    tick(3);
    act_m = cur_drive;
    check_cfg("txdrop");
    checkOutput("txdrop_upd_cnt", upd_cnt - upd0, 1);

    // Short bounce on eight_sw must not be accepted
    upd0 = upd_cnt;
    pend0 = pend_cnt;
    gv = act_m;
    for (int i = 0; i < 5; i++) begin
      gv[2] = ~gv[2];
      applyStimulus(gv, 1'b0, 1'b0);
      tick(1);
    end
    applyStimulus(act_m, 1'b0, 1'b0);
    tick(25);
    checkOutput("bounce_pend_cnt", pend_cnt - pend0, 0);
    checkOutput("bounce_upd_cnt", upd_cnt - upd0, 0);
    check_cfg("bounce");

    // Baud 8 -> 11 -> 8 while the receiver is busy
    applyStimulus({4'd8, 1'b1, 1'b1, 1'b1}, 1'b0, 1'b0);
    wait_baud(19'd868, 16);
    tick(3);
    act_m = cur_drive;
    check_cfg("b8");
    upd0 = upd_cnt;
    applyStimulus({4'd11, 1'b1, 1'b1, 1'b1}, 1'b0, 1'b1);
    tick(20);
    checkOutput("b11_pending", 32'(cfg.cfg_pending), 1);
    applyStimulus({4'd8, 1'b1, 1'b1, 1'b1}, 1'b0, 1'b1);
    tick(20);
    checkOutput("b8back_pending", 32'(cfg.cfg_pending), 0);
    applyStimulus(cur_drive, 1'b0, 1'b0);
    tick(20);
    checkOutput("b8back_upd_cnt", upd_cnt - upd0, 0);
    check_cfg("b8back");

    // Reset asserted while a change is pending
    applyStimulus({4'd0, 1'b1, 1'b1, 1'b1}, 1'b1, 1'b0);
    tick(20);
    checkOutput("prerst_pending", 32'(cfg.cfg_pending), 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    act_m = RESET_VEC;
    check_cfg("midrst");
    checkOutput("midrst_pending", 32'(cfg.cfg_pending), 0);
    checkOutput("midrst_update", 32'(cfg.cfg_update), 0);
    tick(3);
    rst_n = 1'b1;
    applyStimulus(cur_drive, 1'b0, 1'b0);
    tick(1);
    upd0 = upd_cnt;
    mon_en = 1'b1;
    wait_baud(19'd333333, 30);
    tick(3);
    act_m = cur_drive;
    check_cfg("postrst");
    checkOutput("postrst_upd_cnt", upd_cnt - upd0, 1);

    // Randomized phases: bounces, then a held setting under random busy
    for (int p = 0; p < 20; p++) begin
      upd0 = upd_cnt;
      n_gl = $urandom_range(3, 0);
      for (int g = 0; g < n_gl; g++) begin
        do gv = 7'($urandom); while (gv == cur_drive);
        applyStimulus(gv, 1'b0, 1'b0);
        tick($urandom_range(5, 1));
      end
      new_vec = 7'($urandom);
      busy_len = $urandom_range(40, 0);
      tx = 1'b0;
      rx = 1'b0;
      if (busy_len > 0) begin
        tx = 1'($urandom);
        rx = 1'($urandom);
        if (!tx && !rx) tx = 1'b1;
      end
      applyStimulus(new_vec, tx, rx);
      tick(busy_len);
      if (busy_len >= 25) begin
        checkOutput("rnd_busy_pending", 32'(cfg.cfg_pending), 32'(new_vec != act_m));
        check_cfg("rnd_busy");
      end
      applyStimulus(new_vec, 1'b0, 1'b0);
      tick(25);
      checkOutput("rnd_upd_cnt", upd_cnt - upd0, 32'(new_vec != act_m));
      act_m = new_vec;
      check_cfg("rnd");
      checkOutput("rnd_pending", 32'(cfg.cfg_pending), 0);
    end

    checkOutput("glitch_free", bad_cnt, 0);
    checkOutput("upd_width", width_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
